// File: rtl/gpio_status_ctrl.sv
// gpio_status_ctrl
// Board-status controller: launches all cores from one host start request,
// tracks per-core completion, drives per-core / done / error LEDs and a
// watchdog for hung cores.
//
// Optional feature macro: GPIO_BLINK_EN
//   defined   : free-running prescaler; running cores blink (period 2^BLINK_DIV)
//   undefined : no prescaler; running cores show a steady-off LED
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   start_req   host start request (pulse or level)
//   err_clr     clears the error state
//   core_done   per-core completion (pulse or level)
//   core_start  per-core launch pulse (one cycle)
//   led_core    per-core status LED
//   led_done    all cores finished (sticky until next accepted start)
//   led_err     watchdog expired (sticky until err_clr)
//   busy        high while launching / waiting
module gpio_status_ctrl #(
  parameter int NUM_CORES      = 4,
  parameter int BLINK_DIV      = 24,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_req,
  input  logic                 err_clr,
  input  logic [NUM_CORES-1:0] core_done,
  output logic [NUM_CORES-1:0] core_start,
  output logic [NUM_CORES-1:0] led_core,
  output logic                 led_done,
  output logic                 led_err,
  output logic                 busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_DONE, S_ERR} state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_CORES-1:0] r_mask, w_mask_nxt, w_hit;
  logic [TW-1:0]        r_tmo, w_tmo_nxt;
  logic                 r_start_req;
  logic                 w_busy_nxt;
  logic                 w_blink;

  assign w_hit      = r_mask | core_done;
  assign w_busy_nxt = (w_state_nxt == S_START) || (w_state_nxt == S_WAIT);

`ifdef GPIO_BLINK_EN
  logic [BLINK_DIV-1:0] r_pre, w_pre_nxt;
  assign w_pre_nxt = r_pre + 1'b1;
  // Outputs are loaded with next-cycle values, so use the next prescaler MSB.
  assign w_blink   = w_pre_nxt[BLINK_DIV-1];
  always_ff @(posedge clk) begin
    if (rst) r_pre <= '0;
    else     r_pre <= w_pre_nxt;
  end
`else
  assign w_blink = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_tmo_nxt   = r_tmo;
    unique case (r_state)
      S_IDLE: begin
        if (r_start_req) begin
          w_state_nxt = S_START;
          w_mask_nxt  = '0;
        end
      end
      S_START: begin
        w_tmo_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_mask_nxt = w_hit;
        // Completion is tested first so it wins a same-edge race with expiry.
        if (&w_hit)                               w_state_nxt = S_DONE;
        else if (r_tmo == TW'(TIMEOUT_CYCLES-1))  w_state_nxt = S_ERR;
        else                                      w_tmo_nxt   = r_tmo + 1'b1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   if (err_clr) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_tmo       <= '0;
      r_start_req <= 1'b0;
      core_start  <= '0;
      led_core    <= '0;
      led_done    <= 1'b0;
      led_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mask      <= w_mask_nxt;
      r_tmo       <= w_tmo_nxt;
      // Requests are only captured while idle; anything seen elsewhere
      // (including alongside err_clr) is dropped.
      r_start_req <= start_req && (r_state == S_IDLE);
      core_start  <= (w_state_nxt == S_START) ? '1 : '0;
      busy        <= w_busy_nxt;
      led_core    <= w_mask_nxt | (w_busy_nxt ? {NUM_CORES{w_blink}} : '0);
      led_err     <= (w_state_nxt == S_ERR);
      if (w_state_nxt == S_DONE)       led_done <= 1'b1;
      else if (w_state_nxt == S_START) led_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpio_status_ctrl.sv
// Directed bench for gpio_status_ctrl (NUM_CORES=4, BLINK_DIV=2, TIMEOUT=16).
// Expected LED blink values depend on GPIO_BLINK_EN, matching the DUT build.
module tb_gpio_status_ctrl;
  localparam int N = 4, BD = 2, TO = 16;

  logic         clk = 1'b0, rst = 1'b1, start_req = 1'b0, err_clr = 1'b0;
  logic [N-1:0] core_done = '0, core_start, led_core;
  logic         led_done, led_err, busy;

  int n_chk = 0, n_fail = 0;

  logic [N-1:0] e_mask, e_start;
  logic         e_busy, e_done, e_err;

  gpio_status_ctrl #(.NUM_CORES(N), .BLINK_DIV(BD), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start_req(start_req), .err_clr(err_clr),
    .core_done(core_done), .core_start(core_start), .led_core(led_core),
    .led_done(led_done), .led_err(led_err), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef GPIO_BLINK_EN
  // Reference cycle counter: blink phase is its MSB.
  logic [BD-1:0] pre;
  always @(posedge clk) pre <= rst ? '0 : pre + 1'b1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] lc;
    lc = e_mask;
`ifdef GPIO_BLINK_EN
    if (e_busy) lc = e_mask | {N{pre[BD-1]}};
`endif
    chk({tag, ".core_start"}, 32'(core_start), 32'(e_start));
    chk({tag, ".busy"},       32'(busy),       32'(e_busy));
    chk({tag, ".led_done"},   32'(led_done),   32'(e_done));
    chk({tag, ".led_err"},    32'(led_err),    32'(e_err));
    chk({tag, ".led_core"},   32'(led_core),   32'(lc));
  endtask

  // Issue a start pulse and step through the launch cycle into WAIT.
  task automatic launch(input string tag);
    start_req = 1'b1; tick; start_req = 1'b0;
    e_start = '0; e_busy = 1'b0;
    check_all({tag, ".sampled"});
    tick;
    e_start = '1; e_busy = 1'b1; e_mask = '0; e_done = 1'b0; e_err = 1'b0;
    check_all({tag, ".start"});
    tick;
    e_start = '0;
    check_all({tag, ".wait"});
  endtask

  initial begin
    e_mask = '0; e_start = '0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;

    // Reset state
    tick; tick;
    check_all("reset");
    rst = 1'b0;
    tick;
    check_all("idle");

    // Nominal run, done bits in order 0,1,2,3
    launch("nom");
    core_done = 4'b0001; tick; e_mask = 4'b0001; check_all("nom.d0");
    core_done = 4'b0000; tick;                   check_all("nom.gap");
    core_done = 4'b0010; tick; e_mask = 4'b0011; check_all("nom.d1");
    core_done = 4'b0100; start_req = 1'b1;       // start_req in WAIT ignored
    tick; e_mask = 4'b0111; check_all("nom.d2");
    core_done = 4'b0000; start_req = 1'b0;
    tick; check_all("nom.nostart");
    core_done = 4'b1000; tick;
    e_mask = 4'b1111; e_busy = 1'b0; e_done = 1'b1;
    check_all("nom.done");
    core_done = 4'b0000;
    tick; check_all("nom.idle");
    tick; check_all("nom.hold");

    // All cores done on the first WAIT cycle
    start_req = 1'b1; tick; start_req = 1'b0;
    check_all("sim.sampled");               // led_done still held
    tick;
    e_start = '1; e_busy = 1'b1; e_mask = '0; e_done = 1'b0;
    check_all("sim.start");
    tick; e_start = '0; check_all("sim.wait");
    core_done = 4'b1111; tick;
    e_mask = 4'b1111; e_busy = 1'b0; e_done = 1'b1;
    check_all("sim.done");
    core_done = 4'b0000; tick;

    // Watchdog timeout with core 2 hung
    launch("tmo");
    core_done = 4'b1011; tick; e_mask = 4'b1011; check_all("tmo.w1");
    core_done = 4'b0000;
    for (int i = 2; i <= TO - 1; i++) begin
      start_req = (i == 6);
      tick;
      check_all("tmo.wait");
    end
    start_req = 1'b0;
    tick;
    e_busy = 1'b0; e_err = 1'b1;
    check_all("tmo.err");
    start_req = 1'b1; tick; tick;
    check_all("tmo.ignore");
    err_clr = 1'b1; tick;                   // err_clr beats start_req
    err_clr = 1'b0; start_req = 1'b0;
    e_err = 1'b0;
    check_all("tmo.clr");
    tick; tick;
    check_all("tmo.dropped");

    // Last completion on the 16th WAIT cycle: done wins
    launch("race");
    core_done = 4'b0111; tick; e_mask = 4'b0111; check_all("race.w1");
    core_done = 4'b0000;
    for (int i = 2; i <= TO - 1; i++) begin
      tick;
      check_all("race.wait");
    end
    core_done = 4'b1000; tick;
    e_mask = 4'b1111; e_busy = 1'b0; e_done = 1'b1;
    check_all("race.done");
    core_done = 4'b0000; tick;

    // Reset mid-run, then a clean run
    launch("rst");
    core_done = 4'b0011; tick; e_mask = 4'b0011; e_done = 1'b0;
    check_all("rst.partial");
    core_done = 4'b0000;
    rst = 1'b1; tick; rst = 1'b0;
    e_mask = '0; e_busy = 1'b0; e_start = '0;
    check_all("rst.mid");
    tick; tick;
    check_all("rst.quiet");
    launch("clean");
    core_done = 4'b1111; tick;
    e_mask = 4'b1111; e_busy = 1'b0; e_done = 1'b1;
    check_all("clean.done");
    core_done = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
